// File: rtl/t_counter_pkg.sv
// Shared encodings for the T-flip-flop counter sequencer and its core.
package t_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tcnt_core.sv
// Up/down counter built from per-bit T flip-flops; load has priority over en.
// One-cycle latency from en/load to q; no backpressure.
module tcnt_core #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH:0]   up_c;
    logic [WIDTH:0]   dn_c;

    // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
    assign up_c[0] = 1'b1;
    assign dn_c[0] = 1'b1;
    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        assign up_c[i+1] = up_c[i] & q_q[i];
        assign dn_c[i+1] = dn_c[i] & ~q_q[i];
        assign tgl[i]    = en & (dir ? dn_c[i] : up_c[i]);
    end

    always_comb begin
        q_d = q_q ^ tgl;
        if (load) begin
            q_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/t_counter_sequencer.sv
// Sequences a T-flip-flop counter core for one-shot or auto-reload counting.
// All outputs registered (one cycle after the deciding edge); hold pauses stepping.
module t_counter_sequencer
    import t_counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             busy_q, tc_q, tc_d, done_q, done_d;

    logic             core_en, core_load;
    logic [WIDTH-1:0] core_load_val;
    logic [WIDTH-1:0] sv, tv, step_val;

    assign sv       = (dir_q == DIR_DOWN) ? lim_q : '0;
    assign tv       = (dir_q == DIR_DOWN) ? '0 : lim_q;
    // Never wraps: stepping only happens while count has not reached tv.
    assign step_val = (dir_q == DIR_DOWN) ? count - WIDTH'(1) : count + WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        lim_d         = lim_q;
        mode_d        = mode_q;
        dir_d         = dir_q;
        tc_d          = 1'b0;
        done_d        = 1'b0;
        core_en       = 1'b0;
        core_load     = 1'b0;
        core_load_val = sv;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    lim_d         = limit;
                    mode_d        = mode;
                    dir_d         = dir;
                    core_load     = 1'b1;
                    core_load_val = (dir == DIR_DOWN) ? limit : '0;
                    tc_d          = (limit == '0);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    if (count != tv) begin
                        core_en = 1'b1;
                        tc_d    = (step_val == tv);
                    end else if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        core_load = 1'b1;
                        tc_d      = (sv == tv);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            busy_q  <= (state_d == ST_RUN);
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    tcnt_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (core_en),
        .load     (core_load),
        .load_val (core_load_val),
        .dir      (dir_q),
        .q        (count)
    );

    assign busy = busy_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule

// File: tb/tb_t_counter_sequencer.sv
// Directed-vector bench for t_counter_sequencer (WIDTH = 3).
module tb_t_counter_sequencer;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset, start, stop, hold, mode, dir;
    logic [W-1:0] limit;
    logic         busy, tc, done;
    logic [W-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    t_counter_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .hold  (hold),
        .mode  (mode),
        .dir   (dir),
        .limit (limit),
        .busy  (busy),
        .count (count),
        .tc    (tc),
        .done  (done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int e_busy, input int e_count,
                           input int e_tc, input int e_done);
        chk({tag, ".busy"},  busy,  e_busy);
        chk({tag, ".count"}, count, e_count);
        chk({tag, ".tc"},    tc,    e_tc);
        chk({tag, ".done"},  done,  e_done);
    endtask

    task automatic do_start(input logic m, input logic d, input logic [W-1:0] l);
        start = 1'b1; mode = m; dir = d; limit = l;
        tick();
        start = 1'b0;
    endtask

    int exp_seq2 [8] = '{3, 2, 1, 0, 3, 2, 1, 0};
    int exp_seq6 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        mode = 1'b0; dir = 1'b0; limit = '0;
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_out("idle", 0, 0, 0, 0);

        // 1: one-shot up, limit 5
        do_start(1'b0, 1'b0, 3'd5);
        for (int i = 0; i <= 5; i++) begin
            chk_out($sformatf("t1.c%0d", i), 1, i, (i == 5) ? 1 : 0, 0);
            tick();
        end
        chk_out("t1.done", 0, 5, 0, 1);
        tick();
        chk_out("t1.after", 0, 5, 0, 0);

        // 2: auto-reload down, limit 3; dir/limit changes mid-run are ignored
        do_start(1'b1, 1'b1, 3'd3);
        dir = 1'b0; limit = 3'd6; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("t2.c%0d", i), 1, exp_seq2[i], (exp_seq2[i] == 0) ? 1 : 0, 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t2.stop", 0, 3, 0, 0);

        // 3: one-shot up, limit 6, hold three cycles at count 2
        do_start(1'b0, 1'b0, 3'd6);
        tick();
        tick();
        chk_out("t3.pre", 1, 2, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t3.hold%0d", i), 1, 2, 0, 0);
        end
        hold = 1'b0;
        for (int i = 3; i <= 6; i++) begin
            tick();
            chk_out($sformatf("t3.c%0d", i), 1, i, (i == 6) ? 1 : 0, 0);
        end
        tick();
        chk_out("t3.done", 0, 6, 0, 1);

        // 4: auto-reload up, limit 7; start during RUN ignored; stop at 4
        do_start(1'b1, 1'b0, 3'd7);
        tick();
        tick();
        chk_out("t4.c2", 1, 2, 0, 0);
        start = 1'b1; limit = 3'd1; dir = 1'b1;
        tick();
        start = 1'b0;
        chk_out("t4.c3", 1, 3, 0, 0);
        tick();
        chk_out("t4.c4", 1, 4, 0, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t4.stop", 0, 4, 0, 0);
        tick();
        chk_out("t4.idle", 0, 4, 0, 0);

        // 5: limit 0, one-shot then auto-reload
        do_start(1'b0, 1'b0, 3'd0);
        chk_out("t5.os0", 1, 0, 1, 0);
        tick();
        chk_out("t5.osdone", 0, 0, 0, 1);
        do_start(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("t5.ar%0d", i), 1, 0, 1, 0);
            tick();
        end
        hold = 1'b1;
        tick();
        chk_out("t5.arhold", 1, 0, 0, 0);
        hold = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t5.stop", 0, 0, 0, 0);

        // 6: reset mid-run, then limit change mid-run leaves the period alone
        do_start(1'b1, 1'b0, 3'd5);
        tick();
        tick();
        tick();
        chk_out("t6.c3", 1, 3, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("t6.reset", 0, 0, 0, 0);
        tick();
        chk_out("t6.idle", 0, 0, 0, 0);
        do_start(1'b1, 1'b0, 3'd3);
        limit = 3'd1;
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("t6.c%0d", i), 1, exp_seq6[i], (exp_seq6[i] == 3) ? 1 : 0, 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t6.stop", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t_counter_sequencer.md
Name: t_counter_sequencer

Overview:
Controller that sequences a WIDTH-bit T-flip-flop counter core for one-shot or periodic counting.
- On a start request it latches a configuration: terminal limit, mode and direction.
- It then steps the core once per enabled cycle and flags the terminal count.
- It either stops with a done pulse or auto-reloads.
- It sits between control logic and the counter datapath; it is the only agent that drives the core's enable, load and direction.

Parameters:
WIDTH, 3, counter width in bits; legal range 1 to 16.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high; overrides every other input.
start  input  1  start request; accepted only in IDLE.
stop  input  1  abort request; acts only in RUN.
hold  input  1  pause stepping while in RUN.
mode  input  1  0 = one-shot, 1 = auto-reload; sampled at start.
dir  input  1  0 = up, 1 = down; sampled at start.
limit  input  WIDTH  terminal value; sampled at start.
busy  output  1  high while in RUN.
count  output  WIDTH  current counter value.
tc  output  1  terminal-count pulse, registered.
done  output  1  one-cycle completion pulse, one-shot mode only.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (port reset).
- All outputs are registered.
- Reset values: state IDLE, busy 0, count 0, tc 0, done 0.
- States: IDLE and RUN.
- Latched configuration:
  - lim_q, mode_q and dir_q are captured on the accepting start edge.
  - Changes to limit, mode or dir during RUN are ignored.
- Start value (sv) and terminal value (tv):
  - Up: sv = 0, tv = lim_q.
  - Down: sv = lim_q, tv = 0.
- IDLE with start = 1 (stop is ignored in IDLE):
  - Next cycle: state RUN, busy 1, count = sv, tc = (sv == tv), done 0.
- IDLE otherwise: count holds its last value; tc 0, done 0.
- RUN, priority order is stop > hold > step:
  - stop = 1: next cycle state IDLE, busy 0, count held, tc 0, done 0.
  - hold = 1: count frozen, tc 0. A terminal count that arrived before the hold is acted on at the first non-hold edge.
  - Step with count != tv: count moves one toward tv (+1 up, -1 down); tc = (next count == tv).
  - Step with count == tv, one-shot: state IDLE, busy 0, done 1 for one cycle, count stays tv, tc 0.
  - Step with count == tv, auto-reload: count = sv, tc = (sv == tv), state stays RUN.
- start while in RUN is ignored; there is no restart.
- Period:
  - One-shot: busy is high for lim_q+1 cycles; done follows immediately after.
  - Auto-reload: tc fires once every lim_q+1 cycles.
- limit = 0: sv == tv.
  - One-shot: tc 1 for one cycle, then done.
  - Auto-reload: tc stays high on every non-hold cycle.
- No arithmetic wrap occurs. Stepping always stops at tv, so count never passes 0 or 2^WIDTH-1.
- Reset mid-RUN: state returns to IDLE, all outputs to their reset values, and the latched configuration is cleared to 0.

Decomposition:
Shared package t_counter_pkg holds:
- the state encoding (IDLE, RUN);
- mode constants MODE_ONESHOT = 0 and MODE_RELOAD = 1;
- direction constants DIR_UP = 0 and DIR_DOWN = 1.

One sub-module, tcnt_core:
- Inputs: clk, reset, en, load, load_val, dir.
- Output: q.
- Built from per-bit T flip-flops with synchronous reset. Up-count toggle for bit i is the AND of the lower bits; down-count toggle is the AND of their inverses. load has priority over en.
- The sequencer owns all of the FSM, terminal compare, tc/done generation and configuration latches.

Test Plan:
1. Reset, then start with limit=5, mode=0, dir=0 → count 0,1,2,3,4,5 on consecutive cycles with busy 1; tc 1 on the count=5 cycle; next cycle busy 0, done 1, count stays 5.
2. Start with limit=3, mode=1, dir=1 → count repeats 3,2,1,0,3,2,1,0; tc 1 on each count=0 cycle (every 4 cycles); done never asserts.
3. One-shot up with limit=6; hold=1 for 3 cycles while count=2 → count stays 2 and tc stays 0 for those cycles; after release, done occurs 3 cycles later than in the no-hold run.
4. Auto-reload up with limit=7 (WIDTH=3); assert stop when count=4 → next cycle IDLE, busy 0, count 4, done 0. A start asserted during RUN has no effect on count.
5. limit=0, one-shot → tc 1 for 1 cycle, then done 1, count 0. Same with auto-reload → tc held at 1 continuously.
6. Assert reset mid-RUN with count=3 → next cycle busy 0, count 0, tc 0, done 0. Change limit during RUN → the period is unchanged.
